// File: rtl/conv_stream_unit.sv
// -----------------------------------------------------------------------------
// conv_stream_unit
//
// Multi-channel streaming convolution unit. Each accepted beat carries CH
// samples that are shifted into per-channel LEN-deep sliding windows. Once the
// windows are full, every accepted beat starts one serial MAC pass: one tap per
// cycle, with CH multipliers working in parallel. The pass produces a single
// channel-summed dot product. That result is held on a valid/ready output until
// it is consumed.
//
// Configuration macro:
//   CONV_SAT_EN  defined   -> result saturates at 2**RES_W-1
//                undefined -> result is acc[RES_W-1:0] (modulo wrap)
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   clear      in   1             sync flush: empty windows, abort pass, drop result
//   in_data    in   CH*WIDTH      channel c = in_data[c*WIDTH +: WIDTH]
//   in_valid   in   1             in_data valid
//   in_ready   out  1             beat accepted when in_valid & in_ready
//   kernel     in   LEN*CH*WIDTH  tap k, channel c = kernel[(k*CH+c)*WIDTH +: WIDTH]
//   result     out  RES_W         channel-summed dot product
//   out_valid  out  1             result valid
//   out_ready  in   1             result consumed when out_valid & out_ready
// -----------------------------------------------------------------------------
module conv_stream_unit #(
    parameter int WIDTH = 8,
    parameter int LEN   = 4,
    parameter int CH    = 2,
    parameter int RES_W = 2 * WIDTH,
    parameter int ACC_W = 2 * WIDTH + $clog2(LEN * CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [CH*WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LEN*CH*WIDTH-1:0]   kernel,
    output logic [RES_W-1:0]          result,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int TAP_W  = $clog2(LEN);
    localparam int FILL_W = $clog2(LEN + 1);
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              state;
    logic [FILL_W-1:0]   fill_cnt;
    logic [TAP_W-1:0]    tap_cnt;
    logic [ACC_W-1:0]    acc;
    logic [WIDTH-1:0]    win    [CH][LEN];
    logic [WIDTH-1:0]    kern_r [LEN][CH];

    logic [PROD_W-1:0]   prod   [CH];
    logic [ACC_W-1:0]    tap_sum;
    logic [ACC_W-1:0]    acc_next;
    logic                accept;

    // Output mapping of the accumulator: saturate or wrap depending on build.
    function automatic logic [RES_W-1:0] sat_fn(input logic [ACC_W-1:0] a);
`ifdef CONV_SAT_EN
        if (a > ACC_W'({RES_W{1'b1}}))
            return {RES_W{1'b1}};
        else
            return a[RES_W-1:0];
`else
        return a[RES_W-1:0];
`endif
    endfunction

    // Clear has priority over a coincident beat, so the beat is refused.
    assign in_ready = (state == IDLE) && !clear;
    assign accept   = in_valid && in_ready;

    // One tap of every channel per cycle, summed across channels.
    always_comb begin
        tap_sum = '0;
        for (int c = 0; c < CH; c++) begin
            prod[c] = PROD_W'(win[c][tap_cnt]) * PROD_W'(kern_r[tap_cnt][c]);
            tap_sum = tap_sum + ACC_W'(prod[c]);
        end
        acc_next = acc + tap_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            tap_cnt   <= '0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < LEN; k++)
                    win[c][k] <= '0;
            for (int k = 0; k < LEN; k++)
                for (int c = 0; c < CH; c++)
                    kern_r[k][c] <= '0;
        end else if (clear) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            tap_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < LEN; k++)
                    win[c][k] <= '0;
        end else begin
            case (state)
                // Sample intake; enter MAC once this beat leaves the window full.
                IDLE: begin
                    if (accept) begin
                        for (int c = 0; c < CH; c++) begin
                            for (int k = LEN - 1; k > 0; k--)
                                win[c][k] <= win[c][k-1];
                            win[c][0] <= in_data[c*WIDTH +: WIDTH];
                        end
                        if (fill_cnt != FILL_W'(LEN))
                            fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt >= FILL_W'(LEN - 1)) begin
                            state   <= MAC;
                            acc     <= '0;
                            tap_cnt <= '0;
                            for (int k = 0; k < LEN; k++)
                                for (int c = 0; c < CH; c++)
                                    kern_r[k][c] <= kernel[(k*CH+c)*WIDTH +: WIDTH];
                        end
                    end
                end
                // Serial accumulation, one tap per cycle.
                MAC: begin
                    acc     <= acc_next;
                    tap_cnt <= tap_cnt + 1'b1;
                    if (tap_cnt == TAP_W'(LEN - 1)) begin
                        state     <= OUT;
                        result    <= sat_fn(acc_next);
                        out_valid <= 1'b1;
                    end
                end
                // Hold the result until the consumer takes it.
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
